// File: rtl/iterative_muldiv.sv
// iterative_muldiv
//   Multi-cycle unsigned multiply/divide unit. It processes one operand bit
//   per clock: shift-add for multiply, restoring subtract for divide. On
//   completion it issues a single-cycle register-file write request.
//
// Ports
//   clk     in   1      clock, all state changes on posedge
//   reset   in   1      synchronous active-high reset
//   start   in   1      request, accepted only while idle
//   op      in   2      00 MULLO, 01 MULHI, 10 DIVQ, 11 DIVR (unsigned)
//   src_a   in   WIDTH  multiplicand / dividend
//   src_b   in   WIDTH  multiplier / divisor
//   dest    in   AW     destination register for the result
//   busy    out  1      high while an op is running or completing
//   done    out  1      one-cycle completion strobe
//   result  out  WIDTH  result word (register file WD3)
//   waddr   out  AW     destination register (register file A3)
//   we      out  1      write enable (register file WE3), equals done
module iterative_muldiv #(
  parameter int WIDTH = 32,
  parameter int AW    = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic [AW-1:0]    dest,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [AW-1:0]    waddr,
  output logic             we
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_t;

  state_t               state_r;
  state_t               state_s;
  logic [1:0]           op_r;
  logic [WIDTH-1:0]     b_r;
  // Multiply: multiplier bits shifted out MSB-first.
  // Divide: dividend bits shifted out MSB-first while quotient bits shift in.
  logic [WIDTH-1:0]     shft_r;
  logic [2*WIDTH-1:0]   acc_r;
  logic [CW-1:0]        count_r;
  logic [AW-1:0]        dest_r;
  logic [WIDTH-1:0]     result_r;
  logic [AW-1:0]        waddr_r;
  logic                 busy_r;
  logic                 done_r;

  logic                 last_s;
  logic [2*WIDTH-1:0]   acc_s;
  logic [WIDTH-1:0]     shft_s;
  logic [2*WIDTH-1:0]   addend_s;
  logic [WIDTH:0]       shifted_s;
  logic [WIDTH+1:0]     diff_s;
  logic [WIDTH-1:0]     res_s;

  assign last_s = (count_r == CW'(WIDTH - 1));

  // Next-state logic for the IDLE/RUN/FIN sequencer.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) state_s = RUN;
        else       state_s = IDLE;
      end
      RUN: begin
        if (last_s) state_s = FIN;
        else        state_s = RUN;
      end
      FIN:     state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // One iteration of shift-add (multiply) or restoring subtract (divide).
  always_comb begin
    acc_s     = acc_r;
    shft_s    = shft_r;
    addend_s  = shft_r[WIDTH-1] ? {{WIDTH{1'b0}}, b_r} : {(2*WIDTH){1'b0}};
    // Partial remainder stays below 2^WIDTH (it is either < divisor or, for a
    // zero divisor, a prefix of the dividend), so the low WIDTH bits suffice.
    shifted_s = {acc_r[WIDTH-1:0], shft_r[WIDTH-1]};
    diff_s    = {1'b0, shifted_s} - {2'b00, b_r};
    if (op_r[1] == 1'b0) begin
      acc_s  = {acc_r[2*WIDTH-2:0], 1'b0} + addend_s;
      shft_s = {shft_r[WIDTH-2:0], 1'b0};
    end else if (diff_s[WIDTH+1]) begin
      // Trial subtraction borrowed: restore, quotient bit 0.
      acc_s  = {{(WIDTH-1){1'b0}}, shifted_s};
      shft_s = {shft_r[WIDTH-2:0], 1'b0};
    end else begin
      acc_s  = {{(WIDTH-1){1'b0}}, diff_s[WIDTH:0]};
      shft_s = {shft_r[WIDTH-2:0], 1'b1};
    end
  end

  // Result selection from the values produced by the final iteration.
  always_comb begin
    res_s = {WIDTH{1'b0}};
    case (op_r)
      2'b00:   res_s = acc_s[WIDTH-1:0];
      2'b01:   res_s = acc_s[2*WIDTH-1:WIDTH];
      2'b10:   res_s = shft_s;
      2'b11:   res_s = acc_s[WIDTH-1:0];
      default: res_s = {WIDTH{1'b0}};
    endcase
  end

  // State register plus registered status outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= IDLE;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      busy_r  <= (state_s != IDLE);
      done_r  <= (state_s == FIN);
    end
  end

  // Operand capture, iteration datapath and result/address registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      op_r     <= 2'b00;
      b_r      <= {WIDTH{1'b0}};
      shft_r   <= {WIDTH{1'b0}};
      acc_r    <= {(2*WIDTH){1'b0}};
      count_r  <= {CW{1'b0}};
      dest_r   <= {AW{1'b0}};
      result_r <= {WIDTH{1'b0}};
      waddr_r  <= {AW{1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          if (start) begin
            op_r    <= op;
            b_r     <= src_b;
            shft_r  <= src_a;
            acc_r   <= {(2*WIDTH){1'b0}};
            count_r <= {CW{1'b0}};
            dest_r  <= dest;
          end else begin
            count_r <= count_r;
          end
        end
        RUN: begin
          acc_r   <= acc_s;
          shft_r  <= shft_s;
          count_r <= count_r + CW'(1);
          if (last_s) begin
            result_r <= res_s;
            waddr_r  <= dest_r;
          end else begin
            result_r <= result_r;
          end
        end
        FIN:     count_r <= count_r;
        default: count_r <= {CW{1'b0}};
      endcase
    end
  end

  assign busy   = busy_r;
  assign done   = done_r;
  assign we     = done_r;
  assign result = result_r;
  assign waddr  = waddr_r;

endmodule

// File: tb/tb_iterative_muldiv.sv
// Directed self-checking bench for iterative_muldiv. Expected write requests
// are pushed to a scoreboard queue when an op is issued and popped when the
// write-enable pulse appears.
module tb_iterative_muldiv;

  localparam int W  = 32;
  localparam int AW = 5;

  logic          clk;
  logic          reset;
  logic          start;
  logic [1:0]    op;
  logic [W-1:0]  src_a;
  logic [W-1:0]  src_b;
  logic [AW-1:0] dest;
  logic          busy;
  logic          done;
  logic [W-1:0]  result;
  logic [AW-1:0] waddr;
  logic          we;

  int total = 0;
  int bad   = 0;

  logic [W+AW-1:0] exp_q[$];

  iterative_muldiv #(.WIDTH(W), .AW(AW)) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .op     (op),
    .src_a  (src_a),
    .src_b  (src_b),
    .dest   (dest),
    .busy   (busy),
    .done   (done),
    .result (result),
    .waddr  (waddr),
    .we     (we)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Drive one request, push its expectation, and check busy after acceptance.
  task automatic issue(input string tag, input logic [1:0] o, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic [AW-1:0] d, input logic [W-1:0] r);
    @(negedge clk);
    start = 1'b1; op = o; src_a = a; src_b = b; dest = d;
    exp_q.push_back({r, d});
    @(posedge clk); #1;
    start = 1'b0;
    chk({tag, "_busy_acc"}, 64'(busy), 64'd1);
  endtask

  // Wait (bounded) for the write pulse, then check latency, payload and pulse width.
  task automatic complete(input string tag);
    int n;
    logic seen;
    logic gap;
    logic [W+AW-1:0] e;
    n = 0; seen = 1'b0; gap = 1'b0;
    while (n < 100 && !seen) begin
      @(posedge clk); #1;
      n++;
      if (we) seen = 1'b1;
      else if (!busy) gap = 1'b1;
    end
    chk({tag, "_latency"}, 64'(n), 64'(W));
    chk({tag, "_busy_gap"}, 64'(gap), 64'd0);
    if (exp_q.size() > 0) e = exp_q.pop_front();
    else e = '0;
    chk({tag, "_result"}, 64'(result), 64'(e[W+AW-1:AW]));
    chk({tag, "_waddr"}, 64'(waddr), 64'(e[AW-1:0]));
    chk({tag, "_done"}, 64'(done), 64'(seen));
    @(posedge clk); #1;
    chk({tag, "_we_drop"}, 64'(we), 64'd0);
    chk({tag, "_busy_drop"}, 64'(busy), 64'd0);
  endtask

  initial begin
    int we_cnt;
    int we_at;
    logic [W+AW-1:0] e;

    reset = 1'b1; start = 1'b0; op = 2'b00;
    src_a = '0; src_b = '0; dest = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_we", 64'(we), 64'd0);
    chk("rst_result", 64'(result), 64'd0);
    chk("rst_waddr", 64'(waddr), 64'd0);
    @(negedge clk);
    reset = 1'b0;

    // 1: basic multiply
    issue("t1_mullo", 2'b00, 32'd7, 32'd6, 5'd3, 32'd42);
    complete("t1_mullo");

    // 2: full-width multiply
    issue("t2_mullo", 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd4, 32'h0000_0001);
    complete("t2_mullo");
    issue("t2_mulhi", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd5, 32'hFFFF_FFFE);
    complete("t2_mulhi");

    // 3: divide
    issue("t3_divq", 2'b10, 32'd100, 32'd7, 5'd6, 32'd14);
    complete("t3_divq");
    issue("t3_divr", 2'b11, 32'd100, 32'd7, 5'd7, 32'd2);
    complete("t3_divr");
    issue("t3_divq_small", 2'b10, 32'd5, 32'd9, 5'd8, 32'd0);
    complete("t3_divq_small");
    issue("t3_divr_small", 2'b11, 32'd5, 32'd9, 5'd9, 32'd5);
    complete("t3_divr_small");

    // 4: divide by zero
    issue("t4_divq0", 2'b10, 32'd123, 32'd0, 5'd10, 32'hFFFF_FFFF);
    complete("t4_divq0");
    issue("t4_divr0", 2'b11, 32'd123, 32'd0, 5'd11, 32'd123);
    complete("t4_divr0");

    // 5: reset at RUN iteration 10 abandons the op
    issue("t5_abort", 2'b00, 32'd3, 32'd3, 5'd2, 32'd9);
    void'(exp_q.pop_back());
    we_cnt = 0;
    for (int i = 1; i <= 9; i++) begin
      @(posedge clk); #1;
      if (we) we_cnt++;
    end
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    chk("t5_rst_busy", 64'(busy), 64'd0);
    chk("t5_rst_result", 64'(result), 64'd0);
    chk("t5_rst_waddr", 64'(waddr), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < W + 4; i++) begin
      @(posedge clk); #1;
      if (we) we_cnt++;
    end
    chk("t5_no_we", 64'(we_cnt), 64'd0);
    issue("t5_after", 2'b00, 32'd4, 32'd5, 5'd12, 32'd20);
    complete("t5_after");

    // 6: start held high with changing operands
    issue("t6_first", 2'b00, 32'd2, 32'd3, 5'd1, 32'd6);
    we_cnt = 0; we_at = 0;
    for (int i = 1; i <= W + 2; i++) begin
      @(negedge clk);
      start = 1'b1;
      if (i == W + 2) begin
        op = 2'b00; src_a = 32'd9; src_b = 32'd9; dest = 5'd7;
        exp_q.push_back({32'd81, 5'd7});
      end else begin
        op = 2'($urandom_range(3, 0)); src_a = $urandom; src_b = $urandom;
        dest = 5'($urandom_range(31, 0));
      end
      @(posedge clk); #1;
      if (we) begin
        we_cnt++;
        we_at = i;
        if (exp_q.size() > 0) e = exp_q.pop_front();
        else e = '0;
        chk("t6_first_result", 64'(result), 64'(e[W+AW-1:AW]));
        chk("t6_first_waddr", 64'(waddr), 64'(e[AW-1:0]));
      end
      if (i == W + 1) chk("t6_idle_gap", 64'(busy), 64'd0);
      if (i == W + 2) chk("t6_reaccept", 64'(busy), 64'd1);
    end
    start = 1'b0;
    chk("t6_we_count", 64'(we_cnt), 64'd1);
    chk("t6_we_edge", 64'(we_at), 64'(W));
    complete("t6_second");

    chk("sb_empty", 64'(exp_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
